// File: rtl/patch_stim_check_if.sv
// rtl/patch_stim_check_if.sv - stimulus/response bundle between checker and patch under test
interface patch_stim_check_if;
  logic pat_a;
  logic pat_b;
  logic pat_c;
  logic pat_g1;
  logic patch_out;
  logic golden_out;

  modport master (
    output pat_a, pat_b, pat_c, pat_g1,
    input  patch_out, golden_out
  );

  modport slave (
    input  pat_a, pat_b, pat_c, pat_g1,
    output patch_out, golden_out
  );
endinterface

// File: rtl/patch_stim_check.sv
// rtl/patch_stim_check.sv - exhaustive 4-input sweep checker comparing patch against golden response
// Optional response MISR enabled by defining PATCH_CHK_MISR_EN.
module patch_stim_check #(
  parameter int unsigned REPEAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  patch_stim_check_if.master  pif,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          mismatch_cnt,
  output logic [3:0]          first_fail_vec,
  output logic                first_fail_vld,
  output logic [15:0]         signature
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST_SWEEP = 8'(REPEAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [7:0]  sweep_q, sweep_d;
  logic        cmp_q, cmp_d;
  logic        cmp_vld_q, cmp_vld_d;
  logic [3:0]  vec_p_q, vec_p_d;
  logic [7:0]  mm_q, mm_d;
  logic [3:0]  ffv_q, ffv_d;
  logic        ffvld_q, ffvld_d;
  logic [15:0] sig_q, sig_d;

`ifdef PATCH_CHK_MISR_EN
  logic        pout_q, pout_d;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    logic fb;
    fb = s[15] ^ d;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    sweep_d   = sweep_q;
    cmp_d     = pif.patch_out != pif.golden_out;
    cmp_vld_d = 1'b0;
    vec_p_d   = vec_q;
    mm_d      = mm_q;
    ffv_d     = ffv_q;
    ffvld_d   = ffvld_q;
    sig_d     = sig_q;
`ifdef PATCH_CHK_MISR_EN
    pout_d    = pif.patch_out;
    if (cmp_vld_q) sig_d = misr_step(sig_q, pout_q);
`endif

    // Second stage: fold the comparison captured on the previous RUN cycle
    if (cmp_vld_q && cmp_q) begin
      if (mm_q != 8'hFF) mm_d = mm_q + 8'd1;
      if (!ffvld_q) begin
        ffv_d   = vec_p_q;
        ffvld_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 4'd0;
          sweep_d = 8'd0;
          mm_d    = 8'd0;
          ffv_d   = 4'd0;
          ffvld_d = 1'b0;
          sig_d   = 16'h0000;
        end
      end
      RUN: begin
        cmp_vld_d = 1'b1;
        vec_d     = vec_q + 4'd1;
        if (vec_q == 4'd15) begin
          if (sweep_q == LAST_SWEEP) state_d = DRAIN;
          else                       sweep_d = sweep_q + 8'd1;
        end
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= 4'd0;
      sweep_q   <= 8'd0;
      cmp_q     <= 1'b0;
      cmp_vld_q <= 1'b0;
      vec_p_q   <= 4'd0;
      mm_q      <= 8'd0;
      ffv_q     <= 4'd0;
      ffvld_q   <= 1'b0;
      sig_q     <= 16'h0000;
`ifdef PATCH_CHK_MISR_EN
      pout_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      sweep_q   <= sweep_d;
      cmp_q     <= cmp_d;
      cmp_vld_q <= cmp_vld_d;
      vec_p_q   <= vec_p_d;
      mm_q      <= mm_d;
      ffv_q     <= ffv_d;
      ffvld_q   <= ffvld_d;
      sig_q     <= sig_d;
`ifdef PATCH_CHK_MISR_EN
      pout_q    <= pout_d;
`endif
    end
  end

  assign pif.pat_g1     = vec_q[3];
  assign pif.pat_a      = vec_q[2];
  assign pif.pat_b      = vec_q[1];
  assign pif.pat_c      = vec_q[0];
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && (mm_q == 8'd0);
  assign mismatch_cnt   = mm_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = ffvld_q;
`ifdef PATCH_CHK_MISR_EN
  assign signature      = sig_q;
`else
  assign signature      = 16'h0000;
`endif

endmodule

// File: tb/tb_patch_stim_check.sv
// tb/tb_patch_stim_check.sv - self-checking bench for patch_stim_check (REPEAT=1 and REPEAT=20 instances)
module tb_patch_stim_check;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [15:0] patch_tt = 16'h0000;
  logic [15:0] golden_tt = 16'h0000;

  patch_stim_check_if if0 ();
  patch_stim_check_if if1 ();

  assign if0.patch_out  = patch_tt[{if0.pat_g1, if0.pat_a, if0.pat_b, if0.pat_c}];
  assign if0.golden_out = golden_tt[{if0.pat_g1, if0.pat_a, if0.pat_b, if0.pat_c}];
  assign if1.patch_out  = patch_tt[{if1.pat_g1, if1.pat_a, if1.pat_b, if1.pat_c}];
  assign if1.golden_out = golden_tt[{if1.pat_g1, if1.pat_a, if1.pat_b, if1.pat_c}];

  logic busy0, done0, pass0, ffvld0, busy1, done1, pass1, ffvld1;
  logic [7:0] mm0, mm1;
  logic [3:0] ffv0, ffv1;
  logic [15:0] sig0, sig1;

  patch_stim_check #(.REPEAT(1)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .pif(if0.master),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mm0),
    .first_fail_vec(ffv0), .first_fail_vld(ffvld0), .signature(sig0));

  patch_stim_check #(.REPEAT(20)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .pif(if1.master),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mm1),
    .first_fail_vec(ffv1), .first_fail_vld(ffvld1), .signature(sig1));

  int sel = 0;
  logic s_busy, s_done, s_pass, s_ffvld;
  logic [7:0] s_mm;
  logic [3:0] s_ffv, s_vec;
  logic [15:0] s_sig;
  always_comb begin
    s_busy = busy0; s_done = done0; s_pass = pass0; s_ffvld = ffvld0;
    s_mm = mm0; s_ffv = ffv0; s_sig = sig0;
    s_vec = {if0.pat_g1, if0.pat_a, if0.pat_b, if0.pat_c};
    if (sel == 1) begin
      s_busy = busy1; s_done = done1; s_pass = pass1; s_ffvld = ffvld1;
      s_mm = mm1; s_ffv = ffv1; s_sig = sig1;
      s_vec = {if1.pat_g1, if1.pat_a, if1.pat_b, if1.pat_c};
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask

  // Reference: the patch response sequence is the truth table read in vector order, REPEAT times.
  function automatic int model_mm(input logic [15:0] p, input logic [15:0] g, input int reps);
    int n;
    n = $countones(p ^ g) * reps;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int model_ffv(input logic [15:0] p, input logic [15:0] g);
    logic [15:0] d;
    d = p ^ g;
    for (int i = 0; i < 16; i++) if (d[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] model_sig(input logic [15:0] p, input int reps);
`ifdef PATCH_CHK_MISR_EN
    int s;
    s = 0;
    for (int r = 0; r < reps; r++)
      for (int v = 0; v < 16; v++)
        s = ((s << 1) & 32'hFFFF) ^ ((((s >> 15) & 1) ^ int'(p[v])) != 0 ? 32'h1021 : 32'h0);
    return 16'(s);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic do_run(output int edges, output int busy_cycles, input bit mid_start);
    edges = 0;
    busy_cycles = 0;
    @(negedge clk); set_start(1'b1);
    @(posedge clk); edges = 1; #1 set_start(1'b0);
    while (!s_done && edges < 1000) begin
      if (s_busy) busy_cycles++;
      if (mid_start && edges == 5) set_start(1'b1);
      if (mid_start && edges == 6) set_start(1'b0);
      @(posedge clk); edges++; #1;
    end
    set_start(1'b0);
  endtask

  task automatic run_and_check(input string name, input int reps, input bit mid_start);
    int edges, bcyc, emm;
    do_run(edges, bcyc, mid_start);
    emm = model_mm(patch_tt, golden_tt, reps);
    check({name, ".done_edges"}, edges, 16 * reps + 2);
    check({name, ".busy_cycles"}, bcyc, 16 * reps + 1);
    check({name, ".mismatch_cnt"}, s_mm, emm);
    check({name, ".first_fail_vld"}, s_ffvld, emm != 0);
    check({name, ".first_fail_vec"}, s_ffv, model_ffv(patch_tt, golden_tt));
    check({name, ".pass"}, s_pass, emm == 0);
    check({name, ".signature"}, s_sig, model_sig(patch_tt, reps));
  endtask

  typedef struct {
    logic [15:0] p;
    logic [15:0] g;
    int          mm;
    int          ffv;
    bit          vld;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [15:0] sig_a, sig_b;
    int edges, bcyc, wait_cnt;

    tbl[0] = '{16'hA5C3, 16'hA5C3, 0, 0, 1'b0};
    tbl[1] = '{16'h1234, 16'h1234 ^ 16'h0840, 2, 6, 1'b1};
    tbl[2] = '{16'h0F0F, 16'hF0F0, 16, 0, 1'b1};
    tbl[3] = '{16'h0000, 16'h8000, 1, 15, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFF7, 1, 3, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    sel = 0; #0;
    check("rst.busy", busy0, 0);
    check("rst.done", done0, 0);
    check("rst.pass", pass0, 0);
    check("rst.mm", mm0, 0);
    check("rst.ffvld", ffvld0, 0);
    check("rst.vec", s_vec, 0);
    check("rst.sig", sig0, 0);
    @(negedge clk); rst0 = 1'b0; rst1 = 1'b0;

    for (int i = 0; i < 5; i++) begin
      patch_tt = tbl[i].p; golden_tt = tbl[i].g;
      do_run(edges, bcyc, 1'b0);
      check($sformatf("tbl%0d.edges", i), edges, 18);
      check($sformatf("tbl%0d.busy", i), bcyc, 17);
      check($sformatf("tbl%0d.mm", i), s_mm, tbl[i].mm);
      check($sformatf("tbl%0d.ffv", i), s_ffv, tbl[i].ffv);
      check($sformatf("tbl%0d.ffvld", i), s_ffvld, tbl[i].vld);
      check($sformatf("tbl%0d.pass", i), s_pass, tbl[i].mm == 0);
    end

    // Start in DONE (mismatches pending) clears counters and runs immediately
    patch_tt = 16'h00FF; golden_tt = 16'h00FF;
    @(negedge clk); set_start(1'b1);
    @(posedge clk); #1 set_start(1'b0);
    check("restart.busy", s_busy, 1);
    check("restart.mm_cleared", s_mm, 0);
    check("restart.ffvld_cleared", s_ffvld, 0);
    check("restart.done_low", s_done, 0);
    wait_cnt = 0;
    while (!s_done && wait_cnt < 100) begin @(posedge clk); #1 wait_cnt++; end
    check("restart.pass", s_pass, 1);

    // Start pulsed during RUN is ignored
    patch_tt = 16'h3C5A; golden_tt = 16'h3C5A ^ 16'h0100;
    run_and_check("midstart", 1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      patch_tt = 16'($urandom);
      golden_tt = (i % 3 == 0) ? patch_tt : 16'($urandom);
      run_and_check($sformatf("rand%0d", i), 1, 1'b0);
    end

    // Reset at vec 9 mid-run, then restart on the first edge after release
    patch_tt = 16'h0000; golden_tt = 16'h00FF;
    @(negedge clk); set_start(1'b1);
    @(posedge clk); #1 set_start(1'b0);
    wait_cnt = 0;
    while (s_vec != 4'd9 && wait_cnt < 100) begin @(posedge clk); #1 wait_cnt++; end
    check("rstmid.reached_vec9", s_vec, 9);
    @(negedge clk); rst0 = 1'b1;
    @(posedge clk); #1;
    check("rstmid.busy", s_busy, 0);
    check("rstmid.done", s_done, 0);
    check("rstmid.pass", s_pass, 0);
    check("rstmid.mm", s_mm, 0);
    check("rstmid.ffvld", s_ffvld, 0);
    check("rstmid.ffv", s_ffv, 0);
    check("rstmid.vec", s_vec, 0);
    check("rstmid.sig", s_sig, 0);
    rst0 = 1'b0;
    golden_tt = patch_tt;
    run_and_check("after_rst", 1, 1'b0);

`ifdef PATCH_CHK_MISR_EN
    patch_tt = 16'h6B1D; golden_tt = 16'h6B1D;
    run_and_check("misr_a", 1, 1'b0);
    sig_a = s_sig;
    run_and_check("misr_b", 1, 1'b0);
    sig_b = s_sig;
    check("misr.repeatable", sig_b, sig_a);
    check("misr.nonzero", sig_a != 0, 1);
    patch_tt = 16'h6B1D ^ 16'h0010;
    run_and_check("misr_flip", 1, 1'b0);
    check("misr.differs", s_sig != sig_a, 1);
`else
    sig_a = 16'h0; sig_b = 16'h0;
`endif

    sel = 1; #0;
    patch_tt = 16'hC381; golden_tt = ~16'hC381;
    run_and_check("rep20_inv", 20, 1'b0);
    check("rep20.mm_sat", s_mm, 255);
    patch_tt = 16'($urandom); golden_tt = patch_tt ^ 16'h0202;
    run_and_check("rep20_two", 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
